// File: rtl/hid_pkg.sv
// Shared definitions for the HID block: command codes, event types,
// the event record carried through the pacing FIFO, and small helpers.
package hid_pkg;

  // MCU command codes (first byte of a framed transfer)
  localparam logic [7:0] CMD_STATUS = 8'd0;
  localparam logic [7:0] CMD_KBD    = 8'd1;
  localparam logic [7:0] CMD_MOUSE  = 8'd2;
  localparam logic [7:0] CMD_JOY    = 8'd3;
  localparam logic [7:0] CMD_DB9    = 8'd4;

  // Event kinds seen by the Amiga-side consumer
  localparam logic [1:0] EVT_MDX = 2'd0;
  localparam logic [1:0] EVT_MDY = 2'd1;
  localparam logic [1:0] EVT_KBD = 2'd2;

  localparam logic [7:0] HID_VERSION = 8'h02;

  // Keymap result meaning "no Amiga key for this code"
  localparam logic [6:0] KEY_NONE = 7'h7f;

  // One queued event; packed so it can live in a plain FIFO word
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } evt_t;

  // Saturating 8-bit increment for the overflow counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hid_if.sv
// MCU byte link. Strobe is a one-cycle pulse qualifying data_in; there is
// no backpressure, the block accepts every strobed byte. data_out is a
// registered reply that is valid from the cycle after a non-start strobe.
interface hid_if;
  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output data_in_strobe, output data_in_start,
                  output data_in, input data_out);
  modport slave  (input data_in_strobe, input data_in_start,
                  input data_in, output data_out);
endinterface

// File: rtl/hid_evt_fifo.sv
// Synchronous FIFO for paced events. A push while full is accepted only
// when a pop happens in the same cycle; otherwise the word is dropped and
// the caller is expected to account for it.
module hid_evt_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array, contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/keymap.sv
// Keyboard code translation table from MCU scan codes to Amiga raw codes.
// Codes 0x00..0x5f map to code+0x10; everything above has no Amiga key.
module keymap (
  input  logic [6:0] key_in,
  output logic [6:0] key_out
);
  // Pure table lookup, no state
  always_comb begin
    key_out = 7'h7f;
    if (key_in < 7'h60) key_out = key_in + 7'h10;
  end
endmodule

// File: rtl/hid_paced.sv
// HID bridge between the MCU byte link and the Amiga core. Keyboard and
// mouse events are queued and released no closer than EVT_GAP cycles
// apart so a slower consumer can see every level toggle.
module hid_paced #(
  parameter int NUM_JOY    = 2,
  parameter int NUM_DB9    = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int EVT_GAP    = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  hid_if.slave                   mcu,
  input  logic [6*NUM_DB9-1:0]   db9_port,
  output logic                   irq,
  input  logic                   iack,
  output logic [2:0]             mouse_buttons,
  output logic                   kbd_mouse_level,
  output logic [1:0]             kbd_mouse_type,
  output logic [7:0]             kbd_mouse_data,
  output logic [8*NUM_JOY-1:0]   joystick,
  output logic                   ovf_pulse
);
  import hid_pkg::*;

  localparam int GW = $clog2(EVT_GAP);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(EVT_GAP - 1);

  logic                       cmd_stb, byte_stb;
  logic [7:0]                 cmd, dev;
  logic [3:0]                 idx;
  logic [6:0]                 key_code;
  logic                       push, pop, overflow, status_clear;
  evt_t                       push_evt, head_evt;
  logic                       fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
  logic [7:0]                 ovf_cnt;
  logic [GW-1:0]              gap;
  logic [6*NUM_DB9-1:0]       db9_s1, db9_s2, db9_prev;
  logic                       irq_en, irq_set;
  logic [7:0]                 db9_sel;

  assign cmd_stb  = mcu.data_in_strobe &  mcu.data_in_start;
  assign byte_stb = mcu.data_in_strobe & ~mcu.data_in_start;

  keymap u_keymap (
    .key_in  (mcu.data_in[6:0]),
    .key_out (key_code)
  );

  // Command framing: start byte latches the command, data bytes advance idx
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd <= '0;
      idx <= '0;
    end else if (cmd_stb) begin
      cmd <= mcu.data_in;
      idx <= '0;
    end else if (byte_stb && idx != 4'd15) begin
      idx <= idx + 4'd1;
    end
  end

  // Decide whether the current data byte produces a queued event
  always_comb begin
    push     = 1'b0;
    push_evt = '0;
    if (byte_stb) begin
      case (cmd)
        CMD_KBD: if (idx == 4'd0 && key_code != KEY_NONE) begin
          push     = 1'b1;
          push_evt = '{kind: EVT_KBD, data: {mcu.data_in[7], key_code}};
        end
        CMD_MOUSE: if (idx == 4'd1) begin
          push     = 1'b1;
          push_evt = '{kind: EVT_MDX, data: mcu.data_in};
        end else if (idx == 4'd2) begin
          push     = 1'b1;
          push_evt = '{kind: EVT_MDY, data: mcu.data_in};
        end
        default: ;
      endcase
    end
  end

  hid_evt_fifo #(.W(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_evt),
    .pop       (pop),
    .pop_data  (head_evt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  assign pop          = (gap == '0) & ~fifo_empty;
  assign overflow     = push & fifo_full & ~pop;
  assign status_clear = byte_stb & (cmd == CMD_STATUS) & (idx == 4'd3);

  // Dropped-event counter; a read-clear coinciding with a drop leaves 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_cnt   <= '0;
      ovf_pulse <= 1'b0;
    end else begin
      ovf_pulse <= overflow;
      if (status_clear)  ovf_cnt <= overflow ? 8'd1 : 8'd0;
      else if (overflow) ovf_cnt <= sat_inc8(ovf_cnt);
    end
  end

  // Pacing: release one event whenever the gap counter has run out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap             <= '0;
      kbd_mouse_level <= 1'b0;
      kbd_mouse_type  <= '0;
      kbd_mouse_data  <= '0;
    end else if (pop) begin
      gap             <= GAP_RELOAD;
      kbd_mouse_level <= ~kbd_mouse_level;
      kbd_mouse_type  <= head_evt.kind;
      kbd_mouse_data  <= head_evt.data;
    end else if (gap != '0) begin
      gap <= gap - GW'(1);
    end
  end

  // Synchronised DB9 value for the port addressed by idx
  always_comb begin
    db9_sel = '0;
    for (int k = 0; k < NUM_DB9; k++)
      if (idx == 4'(k)) db9_sel = {2'b00, db9_s2[6*k +: 6]};
  end

  // Reply byte; unknown commands leave it untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcu.data_out <= '0;
    end else if (byte_stb) begin
      case (cmd)
        CMD_STATUS: case (idx)
          4'd0:    mcu.data_out <= HID_VERSION;
          4'd2:    mcu.data_out <= 8'(NUM_JOY);
          4'd3:    mcu.data_out <= ovf_cnt;
          default: mcu.data_out <= 8'h00;
        endcase
        CMD_DB9:   mcu.data_out <= db9_sel;
        default:   ;
      endcase
    end
  end

  // Direct-state outputs: mouse buttons and joystick channels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mouse_buttons <= '0;
      dev           <= '0;
      joystick      <= '0;
    end else if (byte_stb) begin
      if (cmd == CMD_MOUSE && idx == 4'd0) mouse_buttons <= mcu.data_in[2:0];
      if (cmd == CMD_JOY && idx == 4'd0)   dev <= mcu.data_in;
      for (int j = 0; j < NUM_JOY; j++)
        if (cmd == CMD_JOY && idx == 4'd1 && dev == 8'(j))
          joystick[8*j +: 8] <= mcu.data_in;
    end
  end

  assign irq_set = irq_en & (db9_s2 != db9_prev);

  // DB9 two-flop synchroniser plus a compare stage for change detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db9_s1   <= '0;
      db9_s2   <= '0;
      db9_prev <= '0;
    end else begin
      db9_s1   <= db9_port;
      db9_s2   <= db9_s1;
      db9_prev <= db9_s2;
    end
  end

  // One-shot change interrupt: arming via CMD4, set beats acknowledge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (irq_set) irq_en <= 1'b0;
      else if (byte_stb && cmd == CMD_DB9 && idx == 4'd0) irq_en <= 1'b1;
      if (irq_set)   irq <= 1'b1;
      else if (iack) irq <= 1'b0;
    end
  end

endmodule
